// File: rtl/ram_io_responder.sv
// ram_io_responder
//
// Byte-wide responder on the CPU's external memory bus. Addresses whose
// bits [17:16] are not 2'b11 hit an on-chip RAM; the 0x30000 region holds
// memory-mapped I/O: a UART transmit FIFO (0x30000), a status byte
// (read 0x30004) and a sticky halt flag (write 0x30004).
//
// Optional feature: define UART_RX_EN to compile in a receive FIFO that
// is filled from rx_data/rx_valid and drained by reads of 0x30000.
//
// Ports
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-low reset
//   mem_a      byte address, only [17:0] decoded
//   mem_wr     1 = write mem_wdata, 0 = read
//   mem_wdata  write byte
//   mem_rdata  registered read byte (one-cycle latency, holds on writes)
//   io_full    TX FIFO full, fed back to the CPU to stall it
//   tx_data    TX FIFO head entry
//   tx_valid   TX FIFO not empty
//   tx_ready   sink accepts tx_data this cycle
//   rx_data    received byte (UART_RX_EN only)
//   rx_valid   rx_data valid (UART_RX_EN only)
//   rx_ready   RX FIFO has room (0 without UART_RX_EN)
//   halt       sticky program-finished flag
//   overflow   sticky, a TX write was dropped because the FIFO was full
module ram_io_responder #(
  parameter int ADDR_W  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        halt,
  output logic        overflow
);

  localparam int          DEPTH   = 1 << FIFO_AW;
  localparam logic [17:0] TX_ADDR = 18'h30000;
  localparam logic [17:0] ST_ADDR = 18'h30004;

  logic [17:0]       dec_a;
  logic              io_sel;
  logic [ADDR_W-1:0] ram_a;
  logic              unused_a;

  assign dec_a    = mem_a[17:0];
  assign io_sel   = (dec_a[17:16] == 2'b11);
  assign ram_a    = mem_a[ADDR_W-1:0];
  assign unused_a = ^mem_a[31:18];

  // RAM array: contents survive reset
  logic [7:0] ram [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (mem_wr && !io_sel)
      ram[ram_a] <= mem_wdata;
  end

  // TX FIFO: extra pointer MSB distinguishes full from empty
  logic [7:0]       tx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp;
  logic             tx_empty, tx_full;
  logic             tx_req, tx_pop, tx_push, tx_drop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]) &&
                    (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]);
  assign tx_valid = ~tx_empty;
  assign io_full  = tx_full;
  assign tx_data  = tx_mem[tx_rp[FIFO_AW-1:0]];

  assign tx_req   = mem_wr && (dec_a == TX_ADDR);
  assign tx_pop   = tx_valid && tx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign tx_push  = tx_req && (!tx_full || tx_pop);
  assign tx_drop  = tx_req && tx_full && !tx_pop;

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wp[FIFO_AW-1:0]] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      halt     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (tx_push)
        tx_wp <= tx_wp + 1'b1;
      if (tx_pop)
        tx_rp <= tx_rp + 1'b1;
      if (tx_drop)
        overflow <= 1'b1;
      if (mem_wr && (dec_a == ST_ADDR))
        halt <= 1'b1;
    end
  end

  // Byte returned by an I/O read of 0x30000
  logic [7:0] rx_rd;

`ifdef UART_RX_EN
  logic [7:0]       rx_mem [DEPTH];
  logic [FIFO_AW:0] rx_wp, rx_rp;
  logic             rx_empty, rx_full;
  logic             rx_push, rx_pop;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]) &&
                    (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]);
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid && rx_ready;
  // Reading the data register consumes the head byte, if any
  assign rx_pop   = !mem_wr && (dec_a == TX_ADDR) && !rx_empty;
  assign rx_rd    = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push)
        rx_wp <= rx_wp + 1'b1;
      if (rx_pop)
        rx_rp <= rx_rp + 1'b1;
    end
  end
`else
  logic unused_rx;

  assign rx_ready  = 1'b0;
  assign rx_rd     = 8'h00;
  assign unused_rx = ^{rx_data, rx_valid};
`endif

  // Read select, stage 0 (combinational, address cycle)
  logic [7:0] rd_p0;

  always_comb begin
    rd_p0 = 8'h00;
    if (!io_sel)
      rd_p0 = ram[ram_a];
    else if (dec_a == ST_ADDR)
      rd_p0 = {6'b0, io_full, ~tx_valid};
    else if (dec_a == TX_ADDR)
      rd_p0 = rx_rd;
  end

  // Stage 1: registered read data, held across write cycles
  always_ff @(posedge clk) begin
    if (!rst)
      mem_rdata <= 8'h00;
    else if (!mem_wr)
      mem_rdata <= rd_p0;
  end

endmodule

// File: doc/ram_io_responder.md
# ram_io_responder

Byte-wide responder on the CPU's external memory bus. It sits on the far side of the memory controller's byte interface and serves 8-bit reads and writes. Addresses below 0x30000 go to an on-chip RAM array. The 0x30000 region is memory-mapped I/O: a UART transmit FIFO, a status byte and a halt register. It also drives `io_full`, which the top level feeds back into the CPU's `rdy_in` to pause the core.

## Interface
- `ADDR_W`, 17, RAM byte-address width (RAM depth 2^ADDR_W bytes)
- `FIFO_AW`, 4, log2 of I/O FIFO depth (depth 16)
- `clk` in 1: single clock; all logic on rising edge
- `rst` in 1: synchronous, active-low reset; sampled on rising edge of `clk`
- `mem_a` in 32: byte address from controller; only bits [17:0] are decoded
- `mem_wr` in 1: 1 = write `mem_wdata` at `mem_a`; 0 = read
- `mem_wdata` in 8: write byte from controller
- `mem_rdata` out 8: registered read byte
- `io_full` out 1: TX FIFO full
- `tx_data` out 8: head of TX FIFO
- `tx_valid` out 1: TX FIFO not empty
- `tx_ready` in 1: sink accepts `tx_data` this cycle
- `rx_data` in 8: input byte (RX path only)
- `rx_valid` in 1: `rx_data` valid (RX path only)
- `rx_ready` out 1: RX FIFO can accept a byte
- `halt` out 1: program-finished flag, sticky
- `overflow` out 1: sticky, TX write dropped while full

## Operation
- **Address decode**
  - I/O region: `mem_a[17:16] == 2'b11`.
  - Otherwise RAM at `mem_a[ADDR_W-1:0]`; bit 17 is ignored for RAM when `ADDR_W=17`.
- **RAM read:** the byte at the address sampled on edge N appears on `mem_rdata` after edge N, i.e. one-cycle latency. Every cycle with `mem_wr=0` performs a read.
- **RAM write:** on an edge with `mem_wr=1`, the array byte is updated. `mem_rdata` holds its previous value; there is no write-through.
- **I/O write 0x30000:** push `mem_wdata` into the TX FIFO.
  - If the FIFO is full and not popping this cycle, the byte is dropped and `overflow` is set.
- **I/O write 0x30004:** `halt` is set, any data value; it stays set until reset.
- **I/O read 0x30004:** `mem_rdata = {6'b0, io_full, ~tx_valid}`.
- **I/O read 0x30000:** behaviour is set under Configuration.
- **Other I/O addresses:** reads return 0x00; writes are ignored.
- **TX FIFO**
  - Circular buffer with `FIFO_AW+1`-bit read and write pointers.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap modulo 2·depth.
  - A pop occurs when `tx_valid && tx_ready`; `tx_data` is the head entry, not registered separately.
  - Push and pop in the same cycle when full: both occur and the count is unchanged.
  - Push when empty: no bypass.
- **`io_full`:** combinational from the pointers.
- **Reset mid-operation:** FIFO contents are discarded and the pointers are cleared. RAM contents are not reset.

## Timing
- Reset values:
  - `mem_rdata` = 0x00
  - `tx_valid` = 0
  - `io_full` = 0
  - `halt` = 0
  - `overflow` = 0
  - `rx_ready` = 1 with RX path, 0 without
  - FIFO pointers = 0
- Read latency: 1 cycle for RAM and for I/O status.
- TX push at edge N → `tx_valid=1` after edge N.
- TX pop at edge N → next entry, or `tx_valid=0`, after edge N.
- `io_full` rises after the edge of the push that fills the FIFO, and falls after the edge of the first pop.

## Configuration
- **`UART_RX_EN` defined**
  - An RX FIFO (same depth and pointer scheme) is compiled in.
  - It pushes when `rx_valid && rx_ready`; `rx_ready = ~rx_full`.
  - An I/O read of 0x30000 returns the head byte next cycle and pops it.
  - If the RX FIFO is empty, the read returns 0x00 and there is no pop.
  - A simultaneous push and pop is allowed.
- **Not defined**
  - No RX logic.
  - `rx_ready` tied to 0; `rx_data` and `rx_valid` are ignored.
  - I/O read of 0x30000 returns 0x00.

## Test plan
- **Reset:** assert `rst=0` for 2 cycles → all outputs at reset values. Write 0x5A to 0x00010, read 0x00010 → `mem_rdata=0x5A` one cycle after the read address.
- **Back-to-back reads:** write 0x11, 0x22, 0x33, 0x44 to 0x01000–0x01003. Read 0x01003, 0x01002, 0x01001, 0x01000 on consecutive cycles → 0x44, 0x33, 0x22, 0x11, each lagging by 1 cycle.
- **TX fill and drain:** hold `tx_ready=0` and write 16 bytes 0x00–0x0F to 0x30000 → `io_full=1`, status read = 0x02. Write a 17th byte → `overflow=1`, FIFO unchanged. Raise `tx_ready` → 0x00–0x0F drained in order, then `tx_valid=0`.
- **Simultaneous push and pop when full:** write 0xAB with `tx_ready=1` → `io_full` stays 1, 0xAB emerges last.
- **Halt:** write 0x00 to 0x30004 → `halt=1` next cycle. Pulse `rst` → `halt=0`.
- **Receive (`UART_RX_EN`):** push 0x61, 0x62 via `rx_valid`, then read 0x30000 three times → 0x61, 0x62, 0x00.
